store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 141 ++++++++++++++
 tb/tb_store_buffer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - committed-store FIFO draining to data memory, with load disambiguation
// Optional load forwarding from the youngest matching store: define STORE_BUFFER_FWD_EN.
module store_buffer #(
  parameter int SB_DEPTH    = 2,
  parameter int SB_NUM_ELEM = 2**SB_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sb_push,
  input  logic [31:0] sb_push_addr,
  input  logic [3:0]  sb_push_wmask,
  input  logic [31:0] sb_push_wdata,
  output logic        store_buffer_full,
  output logic        store_buffer_empty,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  output logic        dmem_write,
  input  logic        dmem_resp,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_rmask,
  output logic        ld_conflict,
  output logic        ld_fwd_hit,
  output logic [31:0] ld_fwd_data
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e                   state_q;
  logic [SB_DEPTH-1:0]      head_q;
  logic [SB_DEPTH-1:0]      tail_q;
  logic [SB_DEPTH:0]        count_q;
  logic [SB_DEPTH:0]        count_d;
  logic [SB_NUM_ELEM-1:0]   valid_q;
  logic [29:0]              word_q  [SB_NUM_ELEM];
  logic [3:0]               wmask_q [SB_NUM_ELEM];
  logic [31:0]              wdata_q [SB_NUM_ELEM];

  logic push_ok;
  logic drain;
  logic in_flight;

  // Byte offset is carried by the lane-aligned mask, so only the word address is kept.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{sb_push_addr[1:0], ld_addr[1:0]};

  assign store_buffer_full  = (count_q == (SB_DEPTH+1)'(SB_NUM_ELEM));
  assign store_buffer_empty = (count_q == '0) && (state_q == IDLE);
  assign push_ok            = sb_push && !store_buffer_full;
  assign in_flight          = (state_q == WRITE);
  assign drain              = in_flight && dmem_resp;

  always_comb begin
    count_d = count_q;
    case ({push_ok, drain})
      2'b10:   count_d = count_q + (SB_DEPTH+1)'(1);
      2'b01:   count_d = count_q - (SB_DEPTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push_ok) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + SB_DEPTH'(1);
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + SB_DEPTH'(1);
      end
      count_q <= count_d;
      case (state_q)
        IDLE:    if (count_q != '0) state_q <= WRITE;
        WRITE:   if (dmem_resp) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      word_q[tail_q]  <= sb_push_addr[31:2];
      wmask_q[tail_q] <= sb_push_wmask;
      wdata_q[tail_q] <= sb_push_wdata;
    end
  end

  // Head is only presented while a write is outstanding, which also zeroes it under reset.
  assign dmem_write = in_flight;
  assign dmem_addr  = in_flight ? {word_q[head_q], 2'b00} : '0;
  assign dmem_wmask = in_flight ? wmask_q[head_q] : '0;
  assign dmem_wdata = in_flight ? wdata_q[head_q] : '0;

  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < SB_NUM_ELEM; i++) begin
      if (valid_q[i] && (word_q[i] == ld_addr[31:2]) && |(wmask_q[i] & ld_rmask))
        ld_conflict = 1'b1;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [SB_DEPTH-1:0] fwd_idx;
  logic                fwd_found;
  logic [3:0]          fwd_mask;
  logic [31:0]         fwd_data;

  // Walk oldest to youngest so the last matching word wins.
  always_comb begin
    fwd_idx   = head_q;
    fwd_found = 1'b0;
    fwd_mask  = '0;
    fwd_data  = '0;
    for (int k = 0; k < SB_NUM_ELEM; k++) begin
      fwd_idx = head_q + SB_DEPTH'(k);
      if (valid_q[fwd_idx] && (word_q[fwd_idx] == ld_addr[31:2])) begin
        fwd_found = 1'b1;
        fwd_mask  = wmask_q[fwd_idx];
        fwd_data  = wdata_q[fwd_idx];
      end
    end
  end

  assign ld_fwd_hit  = fwd_found && ((fwd_mask & ld_rmask) == ld_rmask);
  assign ld_fwd_data = ld_fwd_hit ? fwd_data : '0;
`else
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;

`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        sb_push;
  logic [31:0] sb_push_addr;
  logic [3:0]  sb_push_wmask;
  logic [31:0] sb_push_wdata;
  logic        store_buffer_full;
  logic        store_buffer_empty;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_write;
  logic        dmem_resp;
  logic [31:0] ld_addr;
  logic [3:0]  ld_rmask;
  logic        ld_conflict;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  store_buffer dut (
    .clk               (clk),
    .rst               (rst),
    .sb_push           (sb_push),
    .sb_push_addr      (sb_push_addr),
    .sb_push_wmask     (sb_push_wmask),
    .sb_push_wdata     (sb_push_wdata),
    .store_buffer_full (store_buffer_full),
    .store_buffer_empty(store_buffer_empty),
    .dmem_addr         (dmem_addr),
    .dmem_wmask        (dmem_wmask),
    .dmem_wdata        (dmem_wdata),
    .dmem_write        (dmem_write),
    .dmem_resp         (dmem_resp),
    .ld_addr           (ld_addr),
    .ld_rmask          (ld_rmask),
    .ld_conflict       (ld_conflict),
    .ld_fwd_hit        (ld_fwd_hit),
    .ld_fwd_data       (ld_fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    sb_push = 1'b1; sb_push_addr = a; sb_push_wmask = m; sb_push_wdata = d;
    step();
    sb_push = 1'b0;
  endtask

  task automatic resp();
    dmem_resp = 1'b1;
    step();
    dmem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; sb_push = 1'b0; sb_push_addr = '0; sb_push_wmask = '0; sb_push_wdata = '0;
    dmem_resp = 1'b0; ld_addr = '0; ld_rmask = 4'hF;
    step(); step();
    total_cnt++; if ({store_buffer_full, store_buffer_empty, dmem_write} !== 3'b010) $display("FAIL reset_flags got=%b want=010", {store_buffer_full, store_buffer_empty, dmem_write}); else pass_cnt++;
    total_cnt++; if ({dmem_addr, dmem_wmask, dmem_wdata} !== 68'h0) $display("FAIL reset_dmem got=%h want=0", {dmem_addr, dmem_wmask, dmem_wdata}); else pass_cnt++;
    total_cnt++; if ({ld_conflict, ld_fwd_hit, ld_fwd_data} !== 34'h0) $display("FAIL reset_ld got=%h want=0", {ld_conflict, ld_fwd_hit, ld_fwd_data}); else pass_cnt++;
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    push(32'h100, 4'hF, 32'hDEADBEEF);
    total_cnt++; if ({dmem_write, store_buffer_empty} !== 2'b00) $display("FAIL basic_after_push got=%b want=00", {dmem_write, store_buffer_empty}); else pass_cnt++;
    step();
    total_cnt++; if (dmem_write !== 1'b1) $display("FAIL basic_write got=%b want=1", dmem_write); else pass_cnt++;
    total_cnt++; if ({dmem_addr, dmem_wmask, dmem_wdata} !== {32'h100, 4'hF, 32'hDEADBEEF}) $display("FAIL basic_head got=%h want=%h", {dmem_addr, dmem_wmask, dmem_wdata}, {32'h100, 4'hF, 32'hDEADBEEF}); else pass_cnt++;
    step();
    total_cnt++; if ({dmem_write, dmem_addr} !== {1'b1, 32'h100}) $display("FAIL basic_hold got=%h want=%h", {dmem_write, dmem_addr}, {1'b1, 32'h100}); else pass_cnt++;
    resp();
    total_cnt++; if ({store_buffer_empty, dmem_write} !== 2'b10) $display("FAIL basic_drained got=%b want=10", {store_buffer_empty, dmem_write}); else pass_cnt++;
    step();
    total_cnt++; if ({store_buffer_empty, dmem_write} !== 2'b10) $display("FAIL basic_idle got=%b want=10", {store_buffer_empty, dmem_write}); else pass_cnt++;
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_d [4];
    for (int i = 0; i < 4; i++) push(32'h1000 + 32'(4*i), 4'hF, 32'hA0 + 32'(i));
    total_cnt++; if (store_buffer_full !== 1'b1) $display("FAIL full_set got=%b want=1", store_buffer_full); else pass_cnt++;
    total_cnt++; if (dmem_wdata !== 32'hA0) $display("FAIL full_head got=%h want=000000a0", dmem_wdata); else pass_cnt++;
    push(32'h2000, 4'hF, 32'hEE);
    total_cnt++; if ({store_buffer_full, dmem_wdata} !== {1'b1, 32'hA0}) $display("FAIL full_drop got=%h want=%h", {store_buffer_full, dmem_wdata}, {1'b1, 32'hA0}); else pass_cnt++;
    resp();
    total_cnt++; if ({store_buffer_full, dmem_write} !== 2'b00) $display("FAIL full_after_resp got=%b want=00", {store_buffer_full, dmem_write}); else pass_cnt++;
    push(32'h1010, 4'hF, 32'hA4);
    total_cnt++; if (store_buffer_full !== 1'b1) $display("FAIL full_wrap got=%b want=1", store_buffer_full); else pass_cnt++;
    exp_d[0] = 32'hA1; exp_d[1] = 32'hA2; exp_d[2] = 32'hA3; exp_d[3] = 32'hA4;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if ({dmem_write, dmem_wdata, dmem_addr} !== {1'b1, exp_d[i], 32'h1004 + 32'(4*i)}) $display("FAIL full_drain%0d got=%h want=%h", i, {dmem_write, dmem_wdata, dmem_addr}, {1'b1, exp_d[i], 32'h1004 + 32'(4*i)}); else pass_cnt++;
      resp();
      total_cnt++; if (dmem_write !== 1'b0) $display("FAIL full_gap%0d got=%b want=0", i, dmem_write); else pass_cnt++;
      step();
    end
    total_cnt++; if (store_buffer_empty !== 1'b1) $display("FAIL full_empty got=%b want=1", store_buffer_empty); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_d [4];
    push(32'h300, 4'hF, 32'hB0);
    push(32'h304, 4'hF, 32'hB1);
    total_cnt++; if ({dmem_write, dmem_wdata} !== {1'b1, 32'hB0}) $display("FAIL simul_head got=%h want=%h", {dmem_write, dmem_wdata}, {1'b1, 32'hB0}); else pass_cnt++;
    dmem_resp = 1'b1;
    push(32'h308, 4'hF, 32'hB2);
    dmem_resp = 1'b0;
    total_cnt++; if ({store_buffer_full, store_buffer_empty, dmem_write} !== 3'b000) $display("FAIL simul_flags got=%b want=000", {store_buffer_full, store_buffer_empty, dmem_write}); else pass_cnt++;
    push(32'h30C, 4'hF, 32'hB3);
    total_cnt++; if (store_buffer_full !== 1'b0) $display("FAIL simul_count3 got=%b want=0", store_buffer_full); else pass_cnt++;
    push(32'h310, 4'hF, 32'hB4);
    total_cnt++; if (store_buffer_full !== 1'b1) $display("FAIL simul_count4 got=%b want=1", store_buffer_full); else pass_cnt++;
    exp_d[0] = 32'hB1; exp_d[1] = 32'hB2; exp_d[2] = 32'hB3; exp_d[3] = 32'hB4;
    for (int i = 0; i < 4; i++) begin
      if (dmem_write !== 1'b1) step();
      total_cnt++; if ({dmem_write, dmem_wdata} !== {1'b1, exp_d[i]}) $display("FAIL simul_order%0d got=%h want=%h", i, {dmem_write, dmem_wdata}, {1'b1, exp_d[i]}); else pass_cnt++;
      resp();
    end
    step();
    total_cnt++; if (store_buffer_empty !== 1'b1) $display("FAIL simul_empty got=%b want=1", store_buffer_empty); else pass_cnt++;
  endtask

  task automatic test_conflict();
    push(32'h203, 4'b1000, 32'hAB000000);
    ld_addr = 32'h200; ld_rmask = 4'b0001; #1;
    total_cnt++; if (ld_conflict !== 1'b0) $display("FAIL conf_disjoint got=%b want=0", ld_conflict); else pass_cnt++;
    ld_rmask = 4'b1000; #1;
    total_cnt++; if (ld_conflict !== 1'b1) $display("FAIL conf_overlap got=%b want=1", ld_conflict); else pass_cnt++;
    total_cnt++; if ({ld_fwd_hit, ld_fwd_data} !== (FWD ? {1'b1, 32'hAB000000} : 33'h0)) $display("FAIL conf_fwd got=%h want=%h", {ld_fwd_hit, ld_fwd_data}, (FWD ? {1'b1, 32'hAB000000} : 33'h0)); else pass_cnt++;
    ld_addr = 32'h204; #1;
    total_cnt++; if (ld_conflict !== 1'b0) $display("FAIL conf_other_word got=%b want=0", ld_conflict); else pass_cnt++;
    ld_addr = 32'h200;
    step();
    total_cnt++; if ({dmem_write, ld_conflict, dmem_addr, dmem_wmask} !== {2'b11, 32'h200, 4'b1000}) $display("FAIL conf_inflight got=%h want=%h", {dmem_write, ld_conflict, dmem_addr, dmem_wmask}, {2'b11, 32'h200, 4'b1000}); else pass_cnt++;
    resp();
    total_cnt++; if (ld_conflict !== 1'b0) $display("FAIL conf_drained got=%b want=0", ld_conflict); else pass_cnt++;
    step();
  endtask

  task automatic test_forward();
    push(32'h40, 4'hF, 32'h11111111);
    push(32'h40, 4'hF, 32'h22222222);
    ld_addr = 32'h40; ld_rmask = 4'hF; #1;
    total_cnt++; if (ld_conflict !== 1'b1) $display("FAIL fwd_sw_conflict got=%b want=1", ld_conflict); else pass_cnt++;
    total_cnt++; if ({ld_fwd_hit, ld_fwd_data} !== (FWD ? {1'b1, 32'h22222222} : 33'h0)) $display("FAIL fwd_youngest got=%h want=%h", {ld_fwd_hit, ld_fwd_data}, (FWD ? {1'b1, 32'h22222222} : 33'h0)); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      if (dmem_write !== 1'b1) step();
      resp();
    end
    step();
    total_cnt++; if (store_buffer_empty !== 1'b1) $display("FAIL fwd_sw_drained got=%b want=1", store_buffer_empty); else pass_cnt++;
    push(32'h40, 4'b0001, 32'h00000033);
    ld_rmask = 4'b0001; #1;
    total_cnt++; if ({ld_fwd_hit, ld_fwd_data} !== (FWD ? {1'b1, 32'h33} : 33'h0)) $display("FAIL fwd_lb got=%h want=%h", {ld_fwd_hit, ld_fwd_data}, (FWD ? {1'b1, 32'h33} : 33'h0)); else pass_cnt++;
    ld_rmask = 4'hF; #1;
    total_cnt++; if ({ld_fwd_hit, ld_conflict} !== 2'b01) $display("FAIL fwd_lw_partial got=%b want=01", {ld_fwd_hit, ld_conflict}); else pass_cnt++;
    step();
    resp();
    step();
  endtask

  task automatic test_reset_mid_write();
    push(32'h500, 4'hF, 32'hC0);
    push(32'h504, 4'hF, 32'hC1);
    total_cnt++; if (dmem_write !== 1'b1) $display("FAIL rmid_write got=%b want=1", dmem_write); else pass_cnt++;
    ld_addr = 32'h500; ld_rmask = 4'hF;
    #2 rst = 1'b0; #1;
    total_cnt++; if ({dmem_write, store_buffer_empty, store_buffer_full, ld_conflict} !== 4'b0100) $display("FAIL rmid_async got=%b want=0100", {dmem_write, store_buffer_empty, store_buffer_full, ld_conflict}); else pass_cnt++;
    total_cnt++; if (dmem_addr !== 32'h0) $display("FAIL rmid_addr got=%h want=0", dmem_addr); else pass_cnt++;
    step();
    rst = 1'b1;
    step();
    resp();
    total_cnt++; if ({dmem_write, store_buffer_empty} !== 2'b01) $display("FAIL rmid_late_resp got=%b want=01", {dmem_write, store_buffer_empty}); else pass_cnt++;
    push(32'h600, 4'hF, 32'hD0);
    step();
    total_cnt++; if ({dmem_write, dmem_addr, dmem_wdata} !== {1'b1, 32'h600, 32'hD0}) $display("FAIL rmid_head got=%h want=%h", {dmem_write, dmem_addr, dmem_wdata}, {1'b1, 32'h600, 32'hD0}); else pass_cnt++;
    resp();
    total_cnt++; if (store_buffer_empty !== 1'b1) $display("FAIL rmid_final_empty got=%b want=1", store_buffer_empty); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_wrap();
    test_simultaneous();
    test_conflict();
    test_forward();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
